throw_turn_ctl: RTL and testbench

- Turn scheduler for the throw power bar, which is the single charge-bar/force-meter datapath shared by two players.
- Grants the bar to the active player and gates its charge input from that player's key.
- Latches the released force, fires one launch pulse to the projectile logic, and waits for the flight outcome.
- Updates scores, applies an inter-turn cooldown, then hands the bar to the other player. Sits between keyboard decode and the bar/projectile blocks.

---
 rtl/throw_turn_if.sv | 33 +++
 rtl/throw_turn_ctl.sv | 152 +++++++++++++++
 tb/tb_throw_turn_ctl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/throw_turn_if.sv
// Signal bundle between the turn scheduler and its surroundings (keyboard, bar, projectile).
// The slave modport is the scheduler's view; the master modport is the environment's.
interface throw_turn_if #(
    parameter int unsigned FORCE_W = 10
);
    logic               frame_tick;
    logic               key_p1;
    logic               key_p2;
    logic               restart;
    logic [FORCE_W-1:0] force_in;
    logic               proj_done;
    logic               proj_hit;
    logic               charge_en;
    logic               active_player;
    logic               launch;
    logic [FORCE_W-1:0] launch_force;
    logic [3:0]         score_p1;
    logic [3:0]         score_p2;
    logic               game_over;
    logic               foul;

    modport slave (
        input  frame_tick, key_p1, key_p2, restart, force_in, proj_done, proj_hit,
        output charge_en, active_player, launch, launch_force, score_p1, score_p2,
               game_over, foul
    );

    modport master (
        output frame_tick, key_p1, key_p2, restart, force_in, proj_done, proj_hit,
        input  charge_en, active_player, launch, launch_force, score_p1, score_p2,
               game_over, foul
    );
endinterface

// File: rtl/throw_turn_ctl.sv
// Two-player turn scheduler for the shared throw power bar: charge gating, force capture,
// launch, flight outcome, scoring, cooldown and player hand-over.
module throw_turn_ctl #(
    parameter int unsigned FORCE_W         = 10,
    parameter int unsigned MIN_FORCE       = 4,
    parameter int unsigned SETTLE_CYC      = 2,
    parameter int unsigned FLIGHT_TIMEOUT  = 50_000_000,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned WIN_SCORE       = 5
) (
    input logic           clk,
    input logic           rst_n,
    throw_turn_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle, StCharge, StSettle, StFlight, StCooldown, StGameOver
    } state_e;

    state_e             state_q;
    logic               armed_q;
    logic [31:0]        cnt_q;
    logic               charge_q;
    logic               player_q;
    logic               launch_q;
    logic [FORCE_W-1:0] force_q;
    logic [3:0]         s1_q;
    logic [3:0]         s2_q;
    logic               go_q;
    logic               foul_q;

    logic               key_act;
    logic [3:0]         score_act;
    logic [3:0]         score_inc;
    logic [31:0]        cnt_inc;

    always_comb begin
        key_act   = player_q ? bus.key_p2 : bus.key_p1;
        score_act = player_q ? s2_q : s1_q;
        score_inc = (score_act == 4'hF) ? 4'hF : score_act + 4'd1;
        cnt_inc   = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            charge_q <= 1'b0;
            player_q <= 1'b0;
            launch_q <= 1'b0;
            force_q  <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            go_q     <= 1'b0;
            foul_q   <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            foul_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    charge_q <= 1'b0;
                    // A key already held on entry must be released before it can start a charge
                    if (!key_act) armed_q <= 1'b1;
                    if (armed_q && key_act) begin
                        charge_q <= 1'b1;
                        state_q  <= StCharge;
                    end
                end
                StCharge: begin
                    if (key_act) begin
                        charge_q <= 1'b1;
                    end else begin
                        charge_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_inc >= SETTLE_CYC) begin
                        cnt_q <= '0;
                        if (bus.force_in < FORCE_W'(MIN_FORCE)) begin
                            foul_q  <= 1'b1;
                            state_q <= StCooldown;
                        end else begin
                            force_q  <= bus.force_in;
                            launch_q <= 1'b1;
                            state_q  <= StFlight;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StFlight: begin
                    // proj_done is checked first so it wins over a coincident timeout
                    if (bus.proj_done) begin
                        cnt_q   <= '0;
                        state_q <= StCooldown;
                        if (bus.proj_hit) begin
                            if (player_q) s2_q <= score_inc;
                            else          s1_q <= score_inc;
                            if (score_inc == 4'(WIN_SCORE)) begin
                                go_q    <= 1'b1;
                                state_q <= StGameOver;
                            end
                        end
                    end else if (cnt_q == 32'(FLIGHT_TIMEOUT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StCooldown;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StCooldown: begin
                    if (bus.frame_tick) begin
                        if (cnt_inc >= COOLDOWN_FRAMES) begin
                            cnt_q    <= '0;
                            player_q <= ~player_q;
                            armed_q  <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StGameOver: begin
                    charge_q <= 1'b0;
                    if (bus.restart) begin
                        s1_q     <= '0;
                        s2_q     <= '0;
                        player_q <= 1'b0;
                        go_q     <= 1'b0;
                        armed_q  <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.charge_en     = charge_q;
    assign bus.active_player = player_q;
    assign bus.launch        = launch_q;
    assign bus.launch_force  = force_q;
    assign bus.score_p1      = s1_q;
    assign bus.score_p2      = s2_q;
    assign bus.game_over     = go_q;
    assign bus.foul          = foul_q;

endmodule

// File: tb/tb_throw_turn_ctl.sv
// Randomised turns against a rule-level model; expected launch/foul and turn-end records are
// queued by the driver and checked by an independent monitor.
module tb_throw_turn_ctl;
    localparam int FW = 10, MINF = 4, SETTLE = 2, FTO = 100, CDF = 30, WIN = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    throw_turn_if #(.FORCE_W(FW)) bus ();
    throw_turn_ctl #(.FORCE_W(FW), .MIN_FORCE(MINF), .SETTLE_CYC(SETTLE), .FLIGHT_TIMEOUT(FTO),
                     .COOLDOWN_FRAMES(CDF), .WIN_SCORE(WIN))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { bit is_launch; int force_v; int player; } act_t;
    typedef struct { int s1; int s2; int player; int go; int lf; } end_t;
    act_t lq[$];
    end_t eq[$];

    int total = 0, bad = 0;
    int m_s1 = 0, m_s2 = 0, m_pl = 0, m_lf = 0;
    int tick_div = 0;
    bit prev_ap = 0, prev_go = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, bus.charge_en, bus.active_player, bus.launch, bus.launch_force,
                bus.score_p1, bus.score_p2, bus.game_over, bus.foul};
    endfunction

    // Free-running video frame pulse, one every four clocks
    initial begin
        bus.frame_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.frame_tick = (tick_div == 3);
            tick_div = (tick_div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        act_t a;
        end_t e;
        if (!rst_n) begin
            prev_ap = 0;
            prev_go = 0;
        end else begin
            if (bus.launch || bus.foul) begin
                check("launch_foul_excl", bus.launch & bus.foul, 0);
                if (lq.size() == 0) check("act_queue_nonempty", lq.size(), 1);
                else begin
                    a = lq.pop_front();
                    check("act_kind", bus.launch, a.is_launch);
                    if (bus.launch) check("launch_force", bus.launch_force, a.force_v);
                    check("act_player", bus.active_player, a.player);
                end
            end
            if (bus.active_player !== prev_ap || (bus.game_over && !prev_go)) begin
                if (eq.size() == 0) check("end_queue_nonempty", eq.size(), 1);
                else begin
                    e = eq.pop_front();
                    check("end_score_p1", bus.score_p1, e.s1);
                    check("end_score_p2", bus.score_p2, e.s2);
                    check("end_player", bus.active_player, e.player);
                    check("end_game_over", bus.game_over, e.go);
                    check("end_launch_force", bus.launch_force, e.lf);
                end
            end
            prev_ap = bus.active_player;
            prev_go = bus.game_over;
        end
    end

    task automatic pulse_done(input bit hit);
        bus.proj_done = 1'b1;
        bus.proj_hit  = hit;
        tick(1);
        bus.proj_done = 1'b0;
        bus.proj_hit  = 1'b0;
    endtask

    task automatic mid_reset(input string name);
        rst_n = 1'b0;
        #1 check(name, outs(), 0);
        tick(2);
        rst_n = 1'b1;
        m_s1 = 0; m_s2 = 0; m_pl = 0; m_lf = 0;
    endtask

    // outcome: 0 hit, 1 proj_done one clock after timeout (miss), 2 proj_done on the
    // timeout clock (hit), 3 proj_done with proj_hit=0, 4 reset during flight
    task automatic do_turn(input int hold, input int fv, input int outcome);
        int  ap, lat, n;
        bit  is_foul, hit, got, ft, go;
        act_t a;
        end_t e;
        ap = m_pl;
        if (ap == 0) begin bus.key_p1 = 1'b0; bus.key_p2 = 1'b1; end
        else         begin bus.key_p1 = 1'b1; bus.key_p2 = 1'b0; end
        tick(3);
        check("idle_inactive_key", bus.charge_en, 0);
        if ($urandom_range(0, 1) == 1) begin bus.restart = 1'b1; tick(1); bus.restart = 1'b0; end
        if (ap == 0) bus.key_p1 = 1'b1; else bus.key_p2 = 1'b1;
        check("charge_pre", bus.charge_en, 0);
        tick(1);
        check("charge_start", bus.charge_en, 1);
        tick(hold - 1);
        check("charge_held", bus.charge_en, 1);
        bus.force_in = FW'(fv);

        is_foul = (fv < MINF);
        hit = !is_foul && (outcome == 0 || outcome == 2);
        a.is_launch = !is_foul; a.force_v = fv; a.player = ap;
        lq.push_back(a);
        if (!is_foul) m_lf = fv;
        go = 0;
        if (hit) begin
            if (ap == 0) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
            else         m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
            go = ((ap == 0 ? m_s1 : m_s2) == WIN);
        end
        if (!(outcome == 4 && !is_foul)) begin
            if (!go) m_pl = 1 - ap;
            e.s1 = m_s1; e.s2 = m_s2; e.player = m_pl; e.go = go; e.lf = m_lf;
            eq.push_back(e);
        end

        if (ap == 0) bus.key_p1 = 1'b0; else bus.key_p2 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 1) check("charge_drop", bus.charge_en, 0);
            if (bus.launch || bus.foul) begin lat = i; break; end
        end
        check("release_latency", lat, SETTLE + 1);

        if (!is_foul) begin
            case (outcome)
                0, 3: begin tick($urandom_range(0, 60)); pulse_done(outcome == 0); end
                2:    begin tick(FTO - 1); pulse_done(1'b1); end
                1:    begin tick(FTO); bus.proj_done = 1'b1; bus.proj_hit = 1'b1; end
                default: begin tick(10); mid_reset("rst_in_flight"); return; end
            endcase
        end

        got = 0; n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.game_over || bus.active_player != ap[0]) begin got = 1; break; end
            @(negedge clk); #1 ft = bus.frame_tick;
            @(posedge clk); #1;
            bus.proj_done = 1'b0;
            bus.proj_hit  = 1'b0;
            if (ft) n++;
        end
        check("turn_end_seen", got, 1);
        if (got && !bus.game_over) check("cooldown_frames", n, CDF);
    endtask

    initial begin
        end_t e;
        int r, fv, oc;
        bus.key_p1 = 0; bus.key_p2 = 0; bus.restart = 0; bus.force_in = '0;
        bus.proj_done = 0; bus.proj_hit = 0;
        bus.key_p1 = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", outs(), 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("held_key_after_reset", bus.charge_en, 0);
        bus.key_p1 = 1'b0; tick(1);
        bus.key_p1 = 1'b1; tick(1);
        check("rearm_charge", bus.charge_en, 1);
        tick(5);
        mid_reset("rst_in_charge");
        tick(4);
        check("held_after_charge_reset", bus.charge_en, 0);
        bus.key_p1 = 1'b0;
        tick(2);

        do_turn(200, 40, 0);
        do_turn(20, 2, 0);
        do_turn(15, 100, 1);
        do_turn(10, 300, 2);
        do_turn(12, 50, 4);

        for (int t = 0; t < 80 && !bus.game_over; t++) begin
            fv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MINF - 1)
                                             : $urandom_range(MINF, 1023);
            r  = $urandom_range(0, 9);
            oc = (r <= 5 || r == 9) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
            do_turn($urandom_range(3, 30), fv, oc);
        end
        check("game_over_reached", bus.game_over, 1);

        bus.key_p1 = 1'b1; bus.key_p2 = 1'b1;
        tick(40);
        check("go_keys_ignored", bus.charge_en, 0);
        check("go_hold_p1", bus.score_p1, m_s1);
        check("go_hold_p2", bus.score_p2, m_s2);
        check("go_hold_player", bus.active_player, m_pl);
        bus.key_p2 = 1'b0;

        if (m_pl == 1) begin
            e.s1 = 0; e.s2 = 0; e.player = 0; e.go = 0; e.lf = m_lf;
            eq.push_back(e);
        end
        bus.restart = 1'b1; tick(1); bus.restart = 1'b0;
        m_s1 = 0; m_s2 = 0; m_pl = 0;
        check("restart_p1", bus.score_p1, 0);
        check("restart_p2", bus.score_p2, 0);
        check("restart_player", bus.active_player, 0);
        check("restart_go", bus.game_over, 0);
        tick(5);
        check("held_key_after_restart", bus.charge_en, 0);

        for (int t = 0; t < 3; t++) do_turn($urandom_range(3, 30), $urandom_range(MINF, 1023), 0);

        tick(5);
        check("act_queue_drained", lq.size(), 0);
        check("end_queue_drained", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
